// File: rtl/apple_bus_pkg.sv
// Shared types and address map for the Apple II slot bus responder.
package apple_bus_pkg;

  typedef enum logic [1:0] {
    SEL_DEVSEL   = 2'd0,
    SEL_IOSEL    = 2'd1,
    SEL_IOSTROBE = 2'd2
  } rd_sel_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DRIVE,
    ST_HOLD,
    ST_WRITE
  } state_t;

  localparam logic [15:0] DEVSEL_BASE   = 16'hC080;
  localparam logic [15:0] IOSEL_BASE    = 16'hC000;
  localparam logic [15:0] IOSTROBE_BASE = 16'hC800;
  localparam logic [15:0] EXPROM_CLR    = 16'hCFFF;

endpackage

// File: rtl/apple_bus_slot_decode.sv
// Slot address decode: combinational hit/select/offset for DEVSEL, IOSEL and IOSTROBE.
// APPLE_BUS_RESPONDER_EXPROM_EN adds the expansion-ROM latch that gates IOSTROBE.
module apple_bus_slot_decode
  import apple_bus_pkg::*;
#(
  parameter int SLOT = 4
) (
`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
`endif
  input  logic        enable,
  input  logic [15:0] addr,
  output logic        hit,
  output rd_sel_t     sel,
  output logic [10:0] offset
);

  localparam logic [11:0] DEV_PAGE   = DEVSEL_BASE[15:4] + 12'(SLOT);
  localparam logic [7:0]  IOSEL_PAGE = IOSEL_BASE[15:8] + 8'(SLOT);

  logic dev_hit;
  logic io_hit;
  logic strobe_hit;

  assign dev_hit = enable && (addr[15:4] == DEV_PAGE);
  assign io_hit  = enable && (addr[15:8] == IOSEL_PAGE);

`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
  logic exp_latch;

  assign strobe_hit = enable && exp_latch &&
                      (addr[15:11] == IOSTROBE_BASE[15:11]) && (addr != EXPROM_CLR);

  // $CFFF releases the shared $C800 space even when this card is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_latch <= 1'b0;
    end else if (strobe && (addr == EXPROM_CLR)) begin
      exp_latch <= 1'b0;
    end else if (strobe && io_hit) begin
      exp_latch <= 1'b1;
    end
  end
`else
  assign strobe_hit = 1'b0;
`endif

  always_comb begin
    hit    = dev_hit || io_hit || strobe_hit;
    sel    = SEL_DEVSEL;
    offset = {7'd0, addr[3:0]};
    if (io_hit) begin
      sel    = SEL_IOSEL;
      offset = {3'd0, addr[7:0]};
    end else if (strobe_hit) begin
      sel    = SEL_IOSTROBE;
      offset = addr[10:0];
    end
  end

endmodule

// File: rtl/apple_bus_responder.sv
// Apple II slot responder: decodes bus cycles, fetches read data, drives D bus in Phi0 with timed hold.
// Optional expansion ROM ($C800-$CFFE) enabled by APPLE_BUS_RESPONDER_EXPROM_EN.
module apple_bus_responder
  import apple_bus_pkg::*;
#(
  parameter int CLOCK_SPEED_HZ = 54_000_000,
  parameter int SLOT           = 4,
  parameter int DRIVE_COUNT    = 4,
  parameter int HOLD_COUNT     = 2
) (
  input  logic        clk_logic_i,
  input  logic        system_reset_i,
  input  logic        enable_i,
  input  logic        phi0_i,
  input  logic        phi1_posedge_i,
  input  logic        phi1_negedge_i,
  input  logic        phi0_negedge_i,
  input  logic        addr_strobe_i,
  input  logic [15:0] addr_i,
  input  logic        rw_n_i,
  input  logic        data_strobe_i,
  input  logic [7:0]  data_i,
  output logic        rd_req_o,
  output logic [1:0]  rd_sel_o,
  output logic [10:0] rd_addr_o,
  input  logic        rd_ack_i,
  input  logic [7:0]  rd_data_i,
  output logic        wr_strobe_o,
  output logic [7:0]  wr_data_o,
  output logic [7:0]  a2_d_o,
  output logic        a2_d_oe_o,
  output logic        miss_o
);

  // Phase and hold counts are tuned for a 54 MHz logic clock.
  if (CLOCK_SPEED_HZ != 54_000_000) begin : g_clock_note
  end

  state_t      state;
  logic [5:0]  phase;
  logic [3:0]  hold_cnt;
  logic        acked;
  logic [7:0]  rd_buf;

  logic        hit;
  rd_sel_t     sel;
  logic [10:0] offset;

  apple_bus_slot_decode #(
    .SLOT(SLOT)
  ) u_decode (
`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
    .clk    (clk_logic_i),
    .rst    (system_reset_i),
    .strobe (addr_strobe_i),
`endif
    .enable (enable_i),
    .addr   (addr_i),
    .hit    (hit),
    .sel    (sel),
    .offset (offset)
  );

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      phase <= 6'd0;
    end else if (phi1_posedge_i || phi1_negedge_i) begin
      phase <= 6'd0;
    end else if (phase != 6'd63) begin
      phase <= phase + 6'd1;
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (system_reset_i) begin
      state       <= ST_IDLE;
      hold_cnt    <= 4'd0;
      acked       <= 1'b0;
      rd_buf      <= 8'd0;
      rd_req_o    <= 1'b0;
      rd_sel_o    <= 2'd0;
      rd_addr_o   <= 11'd0;
      wr_strobe_o <= 1'b0;
      wr_data_o   <= 8'd0;
      a2_d_o      <= 8'd0;
      a2_d_oe_o   <= 1'b0;
      miss_o      <= 1'b0;
    end else begin
      rd_req_o    <= 1'b0;
      wr_strobe_o <= 1'b0;
      miss_o      <= 1'b0;
      // A new address phase always ends whatever was in flight, including HOLD.
      if (addr_strobe_i) begin
        a2_d_oe_o <= 1'b0;
        state     <= ST_IDLE;
        if (hit) begin
          rd_sel_o  <= sel;
          rd_addr_o <= offset;
          acked     <= 1'b0;
          if (rw_n_i) begin
            rd_req_o <= 1'b1;
            state    <= ST_WAIT;
          end else begin
            state <= ST_WRITE;
          end
        end
      end else begin
        case (state)
          ST_WAIT: begin
            if (phi0_i && (phase == 6'(DRIVE_COUNT))) begin
              if (acked) begin
                a2_d_o    <= rd_buf;
                a2_d_oe_o <= 1'b1;
                state     <= ST_DRIVE;
              end else begin
                miss_o <= 1'b1;
                state  <= ST_IDLE;
              end
            end else if (rd_ack_i && !acked) begin
              acked  <= 1'b1;
              rd_buf <= rd_data_i;
            end
          end
          ST_DRIVE: begin
            if (phi0_negedge_i) begin
              hold_cnt <= 4'd0;
              state    <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (hold_cnt == 4'(HOLD_COUNT - 1)) begin
              a2_d_oe_o <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end
          ST_WRITE: begin
            if (data_strobe_i) begin
              wr_strobe_o <= 1'b1;
              wr_data_o   <= data_i;
              state       <= ST_IDLE;
            end else if (phi1_posedge_i) begin
              state <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_apple_bus_responder.sv
// Bench for apple_bus_responder: synthetic Apple II bus cycles checked against a timeline model.
module tb_apple_bus_responder;

  localparam int SLOT        = 4;
  localparam int DRIVE_COUNT = 4;
  localparam int HOLD_COUNT  = 2;
  localparam int P           = 14;        // logic clocks per bus phase
  localparam int L           = 2*P + 6;   // one bus cycle plus the start of the next Phi1
  localparam int DEC         = P + 1 + DRIVE_COUNT;

  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic        enable = 1'b1;
  logic        phi0 = 1'b0, phi1_posedge = 1'b0, phi1_negedge = 1'b0, phi0_negedge = 1'b0;
  logic        addr_strobe = 1'b0;
  logic [15:0] addr = 16'd0;
  logic        rw_n = 1'b1;
  logic        data_strobe = 1'b0;
  logic [7:0]  data = 8'd0;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic [10:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [7:0]  rd_data = 8'd0;
  logic        wr_strobe;
  logic [7:0]  wr_data;
  logic [7:0]  a2_d;
  logic        a2_d_oe;
  logic        miss;

  int checks = 0;
  int errors = 0;

  logic [32:0] rec   [L];
  logic [32:0] exp_v [L];

  // Registered outputs hold their last value; the model tracks that here.
  logic [1:0]  m_sel;
  logic [10:0] m_addr;
  logic [7:0]  m_d;
  logic [7:0]  m_wdata;
`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
  logic        m_latch;
`endif

  always #9 clk = ~clk;

  apple_bus_responder #(
    .CLOCK_SPEED_HZ(54_000_000), .SLOT(SLOT), .DRIVE_COUNT(DRIVE_COUNT), .HOLD_COUNT(HOLD_COUNT)
  ) dut (
    .clk_logic_i(clk), .system_reset_i(system_reset), .enable_i(enable), .phi0_i(phi0),
    .phi1_posedge_i(phi1_posedge), .phi1_negedge_i(phi1_negedge), .phi0_negedge_i(phi0_negedge),
    .addr_strobe_i(addr_strobe), .addr_i(addr), .rw_n_i(rw_n),
    .data_strobe_i(data_strobe), .data_i(data),
    .rd_req_o(rd_req), .rd_sel_o(rd_sel), .rd_addr_o(rd_addr),
    .rd_ack_i(rd_ack), .rd_data_i(rd_data),
    .wr_strobe_o(wr_strobe), .wr_data_o(wr_data),
    .a2_d_o(a2_d), .a2_d_oe_o(a2_d_oe), .miss_o(miss)
  );

  // One bus cycle: Phi1 for P clocks (address strobe at t=2), Phi0 for P clocks (data strobe at P+6).
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input logic [7:0] wd,
                           input int ack_at, input logic [7:0] ad, input int rst_at);
    for (int t = 0; t < L; t++) begin
      @(posedge clk); #1;
      phi1_posedge = (t == 0);
      phi1_negedge = (t == P);
      phi0_negedge = (t == 2*P);
      phi0         = (t >= P) && (t < 2*P);
      addr_strobe  = (t == 2);
      addr         = a;
      rw_n         = rw;
      data_strobe  = (t == P + 6);
      data         = wd;
      rd_ack       = (t == ack_at);
      rd_data      = (t == ack_at) ? ad : 8'hEE;
      system_reset = (t == rst_at);
      @(negedge clk);
      rec[t] = {rd_req, rd_sel, rd_addr, a2_d_oe, a2_d, miss, wr_strobe, wr_data};
    end
    system_reset = 1'b0;
  endtask

  // Expected per-clock outputs for one bus cycle, from the bus timing and address map rules.
  task automatic model_cycle(input logic en, input logic [15:0] a, input logic rw, input logic [7:0] wd,
                             input int ack_at, input logic [7:0] ad, input int rst_at);
    int ai, dev_lo, io_lo;
    logic hit, acked, req, oe, miss_e, wr;
    logic [1:0] s;
    logic [10:0] o;
    ai = int'(a);
    dev_lo = 'hC080 + 16*SLOT;
    io_lo  = 'hC000 + 256*SLOT;
    hit = 1'b0; s = 2'd0; o = 11'd0;
    if (en && ai >= dev_lo && ai < dev_lo + 16) begin
      hit = 1'b1; s = 2'd0; o = 11'(ai - dev_lo);
    end else if (en && ai >= io_lo && ai < io_lo + 256) begin
      hit = 1'b1; s = 2'd1; o = 11'(ai - io_lo);
    end
`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
    else if (en && m_latch && ai >= 'hC800 && ai < 'hCFFF) begin
      hit = 1'b1; s = 2'd2; o = 11'(ai - 'hC800);
    end
    if (ai == 'hCFFF) m_latch = 1'b0;
    else if (hit && s == 2'd1) m_latch = 1'b1;
`endif
    acked = (ack_at >= 3) && (ack_at < DEC);
    for (int t = 0; t < L; t++) begin
      req = 1'b0; oe = 1'b0; miss_e = 1'b0; wr = 1'b0;
      if (rst_at >= 0 && t > rst_at) begin
        m_sel = 2'd0; m_addr = 11'd0; m_d = 8'd0; m_wdata = 8'd0;
`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
        m_latch = 1'b0;
`endif
      end else if (hit) begin
        if (t == 3) begin
          m_sel = s; m_addr = o;
        end
        if (rw) begin
          req = (t == 3);
          if (acked) begin
            if (t == DEC + 1) m_d = ad;
            oe = (t > DEC) && (t <= 2*P + HOLD_COUNT);
          end else begin
            miss_e = (t == DEC + 1);
          end
        end else if (t == P + 7) begin
          wr = 1'b1; m_wdata = wd;
        end
      end
      exp_v[t] = {req, m_sel, m_addr, oe, m_d, miss_e, wr, m_wdata};
    end
  endtask

  task automatic test_reset();
    system_reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 system_reset = 1'b0;
    @(negedge clk);
    m_sel = 2'd0; m_addr = 11'd0; m_d = 8'd0; m_wdata = 8'd0;
`ifdef APPLE_BUS_RESPONDER_EXPROM_EN
    m_latch = 1'b0;
`endif
    checks++;
    if ({rd_req, rd_sel, rd_addr, a2_d_oe, a2_d, miss, wr_strobe, wr_data} !== 33'd0) begin
      errors++;
      $display("FAIL reset outputs got %h exp 0",
               {rd_req, rd_sel, rd_addr, a2_d_oe, a2_d, miss, wr_strobe, wr_data});
    end
  endtask

  task automatic test_read_drive();
    model_cycle(1'b1, 16'hC0C3, 1'b1, 8'h00, 8, 8'hA5, -1);
    bus_cycle(16'hC0C3, 1'b1, 8'h00, 8, 8'hA5, -1);
    for (int t = 0; t < L; t++) begin
      checks++;
      if (rec[t] !== exp_v[t]) begin
        errors++; $display("FAIL read_drive t=%0d got %h exp %h", t, rec[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_read_ack_boundary();
    model_cycle(1'b1, 16'hC0C9, 1'b1, 8'h00, DEC - 1, 8'h5B, -1);
    bus_cycle(16'hC0C9, 1'b1, 8'h00, DEC - 1, 8'h5B, -1);
    for (int t = 0; t < L; t++) begin
      checks++;
      if (rec[t] !== exp_v[t]) begin
        errors++; $display("FAIL ack_boundary t=%0d got %h exp %h", t, rec[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_read_miss();
    model_cycle(1'b1, 16'hC4FF, 1'b1, 8'h00, DEC + 1, 8'h77, -1);
    bus_cycle(16'hC4FF, 1'b1, 8'h00, DEC + 1, 8'h77, -1);
    for (int t = 0; t < L; t++) begin
      checks++;
      if (rec[t] !== exp_v[t]) begin
        errors++; $display("FAIL read_miss t=%0d got %h exp %h", t, rec[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_write();
    model_cycle(1'b1, 16'hC0C7, 1'b0, 8'h3C, 8, 8'h11, -1);
    bus_cycle(16'hC0C7, 1'b0, 8'h3C, 8, 8'h11, -1);
    for (int t = 0; t < L; t++) begin
      checks++;
      if (rec[t] !== exp_v[t]) begin
        errors++; $display("FAIL write t=%0d got %h exp %h", t, rec[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_exprom();
    logic [15:0] seq [4];
    seq[0] = 16'hC400; seq[1] = 16'hC812; seq[2] = 16'hCFFF; seq[3] = 16'hC812;
    for (int i = 0; i < 4; i++) begin
      model_cycle(1'b1, seq[i], 1'b1, 8'h00, 9, 8'(8'h40 + i), -1);
      bus_cycle(seq[i], 1'b1, 8'h00, 9, 8'(8'h40 + i), -1);
      for (int t = 0; t < L; t++) begin
        checks++;
        if (rec[t] !== exp_v[t]) begin
          errors++; $display("FAIL exprom step=%0d t=%0d got %h exp %h", i, t, rec[t], exp_v[t]);
        end
      end
    end
  endtask

  task automatic test_reset_in_drive();
    model_cycle(1'b1, 16'hC0C0, 1'b1, 8'h00, 8, 8'h5A, P + 8);
    bus_cycle(16'hC0C0, 1'b1, 8'h00, 8, 8'h5A, P + 8);
    for (int t = 0; t < L; t++) begin
      checks++;
      if (rec[t] !== exp_v[t]) begin
        errors++; $display("FAIL reset_drive t=%0d got %h exp %h", t, rec[t], exp_v[t]);
      end
    end
    model_cycle(1'b1, 16'hC0C0, 1'b1, 8'h00, 6, 8'h96, -1);
    bus_cycle(16'hC0C0, 1'b1, 8'h00, 6, 8'h96, -1);
    for (int t = 0; t < L; t++) begin
      checks++;
      if (rec[t] !== exp_v[t]) begin
        errors++; $display("FAIL after_reset t=%0d got %h exp %h", t, rec[t], exp_v[t]);
      end
    end
  endtask

  task automatic test_disabled();
    logic [15:0] seq [2];
    seq[0] = 16'hC0C0; seq[1] = 16'hC400;
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      model_cycle(1'b0, seq[i], 1'b1, 8'h00, 8, 8'hC3, -1);
      bus_cycle(seq[i], 1'b1, 8'h00, 8, 8'hC3, -1);
      for (int t = 0; t < L; t++) begin
        checks++;
        if (rec[t] !== exp_v[t]) begin
          errors++; $display("FAIL disabled step=%0d t=%0d got %h exp %h", i, t, rec[t], exp_v[t]);
        end
      end
    end
    enable = 1'b1;
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic rw, en;
    logic [7:0] wd, ad;
    int ack_at;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       a = 16'(16'hC0C0 + $urandom_range(0, 15));
        1:       a = 16'(16'hC400 + $urandom_range(0, 255));
        2:       a = 16'(16'hC800 + $urandom_range(0, 2047));
        3:       a = 16'hCFFF;
        4:       a = 16'(16'hC090 + $urandom_range(0, 15));
        default: a = 16'($urandom);
      endcase
      rw     = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 5) != 0);
      wd     = 8'($urandom);
      ad     = 8'($urandom);
      ack_at = $urandom_range(0, 2*P);
      enable = en;
      model_cycle(en, a, rw, wd, ack_at, ad, -1);
      bus_cycle(a, rw, wd, ack_at, ad, -1);
      for (int t = 0; t < L; t++) begin
        checks++;
        if (rec[t] !== exp_v[t]) begin
          errors++;
          $display("FAIL random n=%0d addr=%h rw=%0d en=%0d ack_at=%0d t=%0d got %h exp %h",
                   n, a, rw, en, ack_at, t, rec[t], exp_v[t]);
        end
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_read_drive();
    test_read_ack_boundary();
    test_read_miss();
    test_write();
    test_exprom();
    test_reset_in_drive();
    test_disabled();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apple_bus_responder.md
Name: apple_bus_responder

Overview:
- Drive side of the Apple II slot bus: decodes sampled bus cycles for one slot, requests read data from the card logic, and drives it onto the data bus during Phi0 with a timed turn-off.
- Sits beside the bus sampler.
- Consumes its sampled address, r/w and strobes, plus the Phi edge strobes from bus timing.
- Outputs feed the D-bus transceiver (data plus output enable) and the card's register/ROM logic.

Parameters:
- CLOCK_SPEED_HZ, 54_000_000, logic clock rate (documentation only; counts below are derived for 54 MHz).
- SLOT, 4, slot number 1..7 decoded.
- DRIVE_COUNT, 4, phase-counter value in Phi0 at which the drive decision is made (~74 ns).
- HOLD_COUNT, 2, cycles data stays driven after the Phi0 falling edge (~37 ns hold).

Ports:
- clk_logic_i  in  1  logic clock
- system_reset_i  in  1  synchronous reset, active-high
- enable_i  in  1  card enable; 0 = decode nothing
- phi0_i  in  1  Phi0 level
- phi1_posedge_i  in  1  Phi1 rising strobe
- phi1_negedge_i  in  1  Phi1 falling strobe
- phi0_negedge_i  in  1  Phi0 falling strobe
- addr_strobe_i  in  1  pulse: addr_i/rw_n_i valid (Phi1)
- addr_i  in  16  sampled address
- rw_n_i  in  1  sampled R/W
- data_strobe_i  in  1  pulse: data_i valid (Phi0)
- data_i  in  8  sampled write data
- rd_req_o  out  1  one-cycle read request
- rd_sel_o  out  2  0 DEVSEL, 1 IOSEL, 2 IOSTROBE
- rd_addr_o  out  11  offset inside the selected space
- rd_ack_i  in  1  read data valid
- rd_data_i  in  8  read data
- wr_strobe_o  out  1  one-cycle write pulse
- wr_data_o  out  8  write data
- a2_d_o  out  8  data to bus transceiver
- a2_d_oe_o  out  1  drive enable / transceiver direction
- miss_o  out  1  pulse: read hit but no ack by deadline

Behaviour:
- Reset: every output is 0. FSM goes to IDLE, the phase counter goes to 0, and the expansion latch is cleared.
- Phase counter (6 bits):
  - Cleared on phi1_posedge_i or phi1_negedge_i.
  - Otherwise increments, saturating at 63.
- Address decode, evaluated only on addr_strobe_i with enable_i=1:
  - DEVSEL: $C080+16*SLOT..+15; rd_addr_o = addr[3:0].
  - IOSEL: $Cn00..$CnFF, n = SLOT; rd_addr_o = addr[7:0].
  - IOSTROBE: see Optional Feature; rd_addr_o = addr[10:0].
  - Unused high bits of rd_addr_o are 0.
- FSM states: IDLE, WAIT, DRIVE, HOLD, WRITE.
  - IDLE, read hit: rd_req_o=1 for one cycle the cycle after the strobe, with rd_sel_o/rd_addr_o. Go to WAIT.
  - IDLE, write hit: go to WRITE. rd_sel_o/rd_addr_o are still updated.
  - WAIT: latch rd_data_i on the first rd_ack_i. Later acks in the same cycle are ignored.
  - WAIT at phi0_i=1 and counter==DRIVE_COUNT:
    - If acked: go to DRIVE; a2_d_o=latched data and a2_d_oe_o=1 from the next cycle.
    - If not acked: miss_o pulses one cycle; go to IDLE; no drive.
  - DRIVE: a2_d_oe_o stays 1 until phi0_negedge_i, then go to HOLD.
  - HOLD: count HOLD_COUNT cycles with oe still 1, then oe=0 and go to IDLE. a2_d_o keeps its value (not cleared).
  - WRITE: on data_strobe_i, wr_strobe_o=1 for one cycle with wr_data_o=data_i, then go to IDLE.
  - WRITE, phi1_posedge_i without data_strobe_i: go to IDLE silently.
- Boundaries:
  - An ack in IDLE is ignored.
  - addr_strobe_i in any non-IDLE state aborts: oe=0 the next cycle, then the new cycle is decoded as from IDLE (HOLD overlap is the normal case).
  - enable_i falling mid-cycle does not abort the current cycle; it only blocks new decodes.
  - system_reset_i mid-DRIVE: oe=0 the next cycle.
- Latency: ack must arrive no later than the cycle before counter==DRIVE_COUNT in Phi0.

Optional Feature:
- Macro: APPLE_BUS_RESPONDER_EXPROM_EN.
- With the macro:
  - A 1-bit expansion latch is set by any IOSEL hit.
  - It is cleared by any access to $CFFF, read or write, regardless of enable_i. $CFFF is never a hit.
  - $C800..$CFFE decodes as IOSTROBE only while the latch is set.
  - Set and clear in the same strobe is impossible (disjoint address ranges).
- Without the macro: no latch, and IOSTROBE never hits.

Decomposition:
- Package apple_bus_pkg holds:
  - enum rd_sel_t (SEL_DEVSEL, SEL_IOSEL, SEL_IOSTROBE).
  - FSM state enum.
  - Address constants DEVSEL_BASE=16'hC080, IOSEL_BASE=16'hC000, IOSTROBE_BASE=16'hC800, EXPROM_CLR=16'hCFFF.
- One sub-module, apple_bus_slot_decode: combinational hit/sel/offset, plus the expansion latch under the macro.

Test Plan:
- SLOT=4, read $C0C3, ack 5 cycles after rd_req_o with $A5 -> rd_sel_o=0, rd_addr_o=3; a2_d_oe_o=1 from DRIVE_COUNT+1; a2_d_o=$A5; oe drops exactly 2 cycles after phi0_negedge.
- Read $C4FF, ack after DRIVE_COUNT in Phi0 -> miss_o single pulse; a2_d_oe_o never 1; late ack ignored.
- Write $C0C7 with data $3C -> wr_strobe_o one pulse with wr_data_o=$3C; rd_req_o stays 0; oe stays 0.
- Macro on: read $C400 (ack), then read $C812 -> IOSTROBE request with rd_addr_o=$012; then read $CFFF, then read $C812 -> no request on either.
- Assert system_reset_i during DRIVE -> oe 0 the next cycle; all outputs 0; next read $C0C0 is served normally.
- enable_i=0, read $C0C0 and $C400 -> no rd_req_o, no miss_o, oe 0.
